fractal_sync_requester: RTL and testbench
=========================================

Name: fractal_sync_requester

Overview:
- Leaf-side initiator for the fractal synchronization tree. It drives one slave port of a fractal_sync node (sync, level, ack) and consumes that port's wake and error.
- It converts a core-facing request/response handshake into the tree protocol:
  - encodes the target tree level,
  - issues the sync pulse,
  - waits for wake, samples error and acknowledges,
  - returns status to the core, then holds off new requests until the node releases wake.

Parameters:
- LVL_WIDTH, default 2: width of level_o; equals the SLV_WIDTH of the attached node. Must be >0.
- IDX_WIDTH, default max(1, $clog2(LVL_WIDTH)): width of req_level_i.
- CNT_WIDTH, default 16: width of the wait-latency counter rsp_cycles_o. Must be >0.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset: synchronous, active-low, one clock.
- req_valid_i  in  1  core sync request valid.
- req_ready_o  out  1  requester can accept a request.
- req_level_i  in  IDX_WIDTH  target tree level index; 0 = first node above the leaf.
- rsp_valid_o  out  1  response valid; held until accepted.
- rsp_ready_i  in  1  core accepts the response.
- rsp_error_o  out  1  barrier completed with error, or the request was invalid.
- rsp_cycles_o  out  CNT_WIDTH  cycles from the sync pulse to the first wake, saturating.
- sync_o  out  1  sync request to the node; single-cycle pulse.
- level_o  out  LVL_WIDTH  one-hot encoded level; stable while busy.
- ack_o  out  1  wake acknowledge to the node; single-cycle pulse.
- wake_i  in  1  wake from the node.
- error_i  in  1  error from the node; valid while the node holds wake.

Behaviour:
- Reset (rstn_i=0 at a clock edge):
  - FSM goes to IDLE.
  - sync_o, ack_o, rsp_valid_o, rsp_error_o, rsp_cycles_o and level_o all 0.
  - req_ready_o is 1 from the first cycle after reset.
- Reset mid-operation: aborts immediately with the values above, no ack issued. The attached node must be reset in the same cycle; this is a system requirement, not checked here.
- Level encoding: level_o = 1 << req_level_i. The node treats bit0 as "synchronize here" and forwards level>>1 upward.
- Registers: level_o, rsp_error_o and rsp_cycles_o are registered. sync_o, ack_o, req_ready_o and rsp_valid_o are decoded from state.
- FSM states: IDLE, ISSUE, WAIT_WAKE, ACK, RESP, DRAIN.
  - IDLE: req_ready_o=1.
    - On req_valid_i with req_level_i < LVL_WIDTH: load level_o, clear counter, go to ISSUE.
    - On req_valid_i with req_level_i >= LVL_WIDTH: no sync issued; rsp_error_o<=1, rsp_cycles_o<=0, level_o stays 0, go to RESP.
  - ISSUE: sync_o=1 for exactly this cycle; counter +1; go to WAIT_WAKE unconditionally.
    - A wake_i seen in this cycle is not consumed; the node holds wake until acked, so it is seen in WAIT_WAKE.
  - WAIT_WAKE: no timeout.
    - wake_i=0: counter +1, saturating at all-ones.
    - wake_i=1: go to ACK.
  - ACK: ack_o=1 for exactly this cycle; rsp_error_o <= error_i | ~wake_i.
    - wake_i low here is a protocol violation and is flagged as an error.
    - Go to RESP.
  - RESP: rsp_valid_o=1; rsp_error_o and rsp_cycles_o stable.
    - On rsp_ready_i: level_o<=0; if wake_i=0 go to IDLE, else go to DRAIN.
  - DRAIN: wait for wake_i=0, then go to IDLE.
    - A sync issued while the node is still in its SYNC state would be cleared and lost; this wait prevents it.
- Latency:
  - Accept at cycle 0 gives sync_o at cycle 1.
  - First wake at cycle W gives ack_o at W+1 and rsp_valid_o from W+2.
  - rsp_cycles_o = W-1.
  - Minimum request-to-response latency: 4 cycles.
- Response handshake: rsp_valid_o and rsp_error_o never deassert before rsp_ready_i. rsp_ready_i outside RESP is ignored.
- Simultaneous events:
  - rsp_ready_i together with wake_i=0 goes straight to IDLE.
  - req_valid_i outside IDLE is ignored (req_ready_o=0).
- No back-to-back requests: the earliest next accept is the cycle after returning to IDLE.

Test Plan:
- LVL_WIDTH=3, req_level_i=0; node raises wake at cycle 2 and holds it until ack → sync_o pulse at cycle 1 with level_o=3'b001; ack_o at cycle 3; rsp_valid_o at cycle 4 with rsp_error_o=0, rsp_cycles_o=1.
- req_level_i=2, wake delayed to cycle 11 → level_o=3'b100 held through the barrier; rsp_cycles_o=10.
- req_level_i=3 with LVL_WIDTH=3 → no sync_o; rsp_valid_o the next cycle with rsp_error_o=1, rsp_cycles_o=0.
- Node drives error_i=1 one cycle after wake rises → rsp_error_o=1.
- Keep wake_i high 5 cycles after ack, with rsp_ready_i=1 immediately → FSM sits in DRAIN; req_ready_o=0 until the cycle after wake_i falls; a req_valid_i held during DRAIN is not accepted and no sync_o is issued.
- CNT_WIDTH=4 with wake arriving after 30 cycles → rsp_cycles_o=4'hF.
- Assert rstn_i=0 in WAIT_WAKE → next cycle all outputs 0, req_ready_o=1, no ack_o.

Source files
------------

// File: rtl/fractal_sync_requester.sv
// Leaf-side initiator for the fractal synchronization tree: turns a core
// request/response handshake into sync/level/ack toward one node slave port.
module fractal_sync_requester #(
    parameter int LVL_WIDTH = 2,
    parameter int IDX_WIDTH = (LVL_WIDTH > 1) ? $clog2(LVL_WIDTH) : 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [IDX_WIDTH-1:0] req_level_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_error_o,
    output logic [CNT_WIDTH-1:0] rsp_cycles_o,
    output logic                 sync_o,
    output logic [LVL_WIDTH-1:0] level_o,
    output logic                 ack_o,
    input  logic                 wake_i,
    input  logic                 error_i
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_WAKE,
        ACK,
        RESP,
        DRAIN
    } state_e;

    localparam logic [31:0] LVL_MAX = LVL_WIDTH;

    state_e               state_q, state_d;
    logic [LVL_WIDTH-1:0] level_q, level_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 lvl_ok;

    assign lvl_ok  = 32'(req_level_i) < LVL_MAX;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        sync_o      = 1'b0;
        ack_o       = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    cnt_d = '0;
                    if (lvl_ok) begin
                        level_d = LVL_WIDTH'(1) << req_level_i;
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        level_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                sync_o  = 1'b1;
                cnt_d   = cnt_inc;
                state_d = WAIT_WAKE;
            end
            WAIT_WAKE: begin
                if (wake_i) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ACK: begin
                ack_o   = 1'b1;
                // wake dropping before our ack is a protocol violation
                err_d   = error_i | ~wake_i;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    level_d = '0;
                    state_d = wake_i ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!wake_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            level_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o      = level_q;
    assign rsp_error_o  = err_q;
    assign rsp_cycles_o = cnt_q;

endmodule

// File: tb/tb_fractal_sync_requester.sv
// Randomized bench for fractal_sync_requester against a timeline model of
// each barrier transaction (LVL_WIDTH=3, CNT_WIDTH=4).
module tb_fractal_sync_requester;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_level;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_error;
    logic [3:0] rsp_cycles;
    logic       sync;
    logic [2:0] level;
    logic       ack;
    logic       wake;
    logic       error;

    int n_chk  = 0;
    int n_fail = 0;

    fractal_sync_requester #(
        .LVL_WIDTH(3),
        .CNT_WIDTH(4)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_level_i (req_level),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_error_o (rsp_error),
        .rsp_cycles_o(rsp_cycles),
        .sync_o      (sync),
        .level_o     (level),
        .ack_o       (ack),
        .wake_i      (wake),
        .error_i     (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // One barrier: wake rises at cycle w (accept = cycle 0), the node keeps
    // it high hold cycles past the ack, the core accepts rdly cycles late.
    task automatic txn(input int lvl, input int w, input bit err,
                       input int hold, input int rdly);
        bit         ok;
        int         rs, r, wlow, idle, expc;
        logic [2:0] oh;
        ok   = lvl < 3;
        oh   = ok ? 3'(1 << lvl) : 3'b000;
        rs   = ok ? w + 2 : 1;
        r    = rs + rdly;
        wlow = ok ? w + 2 + hold : 0;
        idle = ((r > wlow) ? r : wlow) + 1;
        expc = ok ? ((w - 1 > 15) ? 15 : w - 1) : 0;
        chk("idle_ready", req_ready, 1);
        chk("idle_rspv", rsp_valid, 0);
        chk("idle_level", level, 0);
        req_valid = 1'b1;
        req_level = 2'(lvl);
        rsp_ready = 1'b0;
        wake      = 1'b0;
        error     = 1'b0;
        step();
        for (int c = 1; c < idle; c++) begin
            chk("sync", sync, 32'(c == 1 && ok));
            chk("ack", ack, 32'(ok && c == w + 1));
            chk("busy_ready", req_ready, 0);
            chk("rspv", rsp_valid, 32'(c >= rs && c <= r));
            chk("level", level, (c <= r) ? oh : 3'b000);
            if (c >= rs && c <= r) begin
                chk("rsp_err", rsp_error, ok ? 32'(err) : 1);
                chk("cycles", rsp_cycles, expc);
            end
            req_valid = 1'($urandom_range(0, 1));
            req_level = 2'($urandom_range(0, 3));
            rsp_ready = (c == r) ||
                        ((c < rs || c > r) && $urandom_range(0, 1) == 1);
            wake      = ok && c >= w && c <= w + 1 + hold;
            error     = wake && err && c >= w + 1;
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        wake      = 1'b0;
        error     = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_level = '0;
        rsp_ready = 1'b0;
        wake      = 1'b0;
        error     = 1'b0;
        step();
        step();
        chk("rst_ready", req_ready, 1);
        chk("rst_sync", sync, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_err", rsp_error, 0);
        chk("rst_cycles", rsp_cycles, 0);
        chk("rst_level", level, 0);
        rstn = 1'b1;
        step();

        txn(0, 2, 1'b0, 0, 0);
        txn(2, 11, 1'b0, 0, 2);
        txn(3, 0, 1'b0, 0, 0);
        txn(1, 4, 1'b1, 0, 1);
        txn(1, 3, 1'b0, 5, 0);
        txn(0, 30, 1'b0, 0, 0);

        // reset while waiting for wake, with wake arriving that same cycle
        chk("mr_ready0", req_ready, 1);
        req_valid = 1'b1;
        req_level = 2'd1;
        step();
        req_valid = 1'b0;
        chk("mr_sync", sync, 1);
        chk("mr_level", level, 3'b010);
        step();
        chk("mr_ack_wait", ack, 0);
        wake = 1'b1;
        rstn = 1'b0;
        step();
        chk("mr_ready", req_ready, 1);
        chk("mr_ack", ack, 0);
        chk("mr_sync0", sync, 0);
        chk("mr_rspv", rsp_valid, 0);
        chk("mr_err", rsp_error, 0);
        chk("mr_cycles", rsp_cycles, 0);
        chk("mr_level0", level, 0);
        rstn = 1'b1;
        wake = 1'b0;
        step();

        for (int i = 0; i < 40; i++) begin
            txn($urandom_range(0, 3), $urandom_range(2, 25),
                1'($urandom_range(0, 1)), $urandom_range(0, 4),
                $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
